// File: rtl/avl_mm_arb_pkg.sv
// rtl/avl_mm_arb_pkg.sv - shared types, response codes and width helper for the Avalon-MM arbiter
package avl_mm_arb_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/avl_mm_id_fifo.sv
// rtl/avl_mm_id_fifo.sv - synchronous FIFO of outstanding read channel IDs
module avl_mm_id_fifo
  import avl_mm_arb_pkg::*;
#(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/avl_mm_rr_arbiter.sv
// rtl/avl_mm_rr_arbiter.sv - N-channel round-robin Avalon-MM arbiter with pipelined read return routing
module avl_mm_rr_arbiter
  import avl_mm_arb_pkg::*;
#(
  parameter int N_CH     = 2,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_PEND = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_CH*AW-1:0]     in_address,
  input  logic [N_CH-1:0]        in_read,
  input  logic [N_CH-1:0]        in_write,
  input  logic [N_CH*DW-1:0]     in_writedata,
  input  logic [N_CH*DW/8-1:0]   in_byteenable,
  output logic [N_CH-1:0]        in_waitrequest,
  output logic [DW-1:0]          in_readdata,
  output logic [N_CH-1:0]        in_readdatavalid,
  output logic [1:0]             in_response,
  output logic [AW-1:0]          out_address,
  output logic                   out_read,
  output logic                   out_write,
  output logic [DW-1:0]          out_writedata,
  output logic [DW/8-1:0]        out_byteenable,
  input  logic                   out_waitrequest,
  input  logic [DW-1:0]          out_readdata,
  input  logic                   out_readdatavalid,
  input  logic [1:0]             out_response,
  output logic                   err_orphan
);

  localparam int GW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int IW = $clog2(N_CH) + 1;
  localparam int BW = DW / 8;

  arb_state_e      state, state_nxt;
  logic            lock;
  logic [GW-1:0]   gnt, last_gnt, pick, sel;
  logic            pick_vld, issue, accept, sel_rd, read_block;
  logic [N_CH-1:0] req, elig;
  logic            fifo_full, fifo_empty;
  logic [IW-1:0]   fifo_head;

  // A full ID FIFO blocks reads unless a return frees a slot this cycle.
  assign read_block = fifo_full & ~out_readdatavalid;
  assign req        = in_read | in_write;
  assign elig       = req & ~(in_read & {N_CH{read_block}});

  always_comb begin
    logic [GW-1:0] idx;
    pick     = last_gnt;
    pick_vld = 1'b0;
    idx      = '0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = GW'((int'(last_gnt) + k) % N_CH);
      if (!pick_vld && elig[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ARB_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = ARB_IDLE;
    if (issue && out_waitrequest) state_nxt = ARB_BUSY;
  end

  always_comb begin
    lock   = (state == ARB_BUSY);
    sel    = lock ? gnt : pick;
    issue  = lock ? elig[gnt] : pick_vld;
    sel_rd = in_read[sel];
    accept = issue & ~out_waitrequest;
    out_read  = issue & sel_rd;
    out_write = issue & ~sel_rd;
    in_waitrequest = '1;
    if (accept) in_waitrequest[sel] = 1'b0;
  end

  assign out_address    = in_address[sel*AW +: AW];
  assign out_writedata  = in_writedata[sel*DW +: DW];
  assign out_byteenable = in_byteenable[sel*BW +: BW];

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt        <= '0;
      last_gnt   <= GW'(N_CH - 1);
      err_orphan <= 1'b0;
    end else begin
      if (issue)  gnt      <= sel;
      if (accept) last_gnt <= sel;
      if (out_readdatavalid && fifo_empty) err_orphan <= 1'b1;
    end
  end

  avl_mm_id_fifo #(
    .W     (IW),
    .DEPTH (MAX_PEND)
  ) u_id_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept & sel_rd),
    .push_data (IW'(sel)),
    .pop       (out_readdatavalid),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    in_readdatavalid = '0;
    for (int i = 0; i < N_CH; i++)
      in_readdatavalid[i] = out_readdatavalid & ~fifo_empty & (fifo_head == IW'(i));
  end

  assign in_readdata = out_readdata;
  assign in_response = out_response;

endmodule

// File: tb/tb_avl_mm_rr_arbiter.sv
// tb/tb_avl_mm_rr_arbiter.sv - directed vector table plus randomized model check for avl_mm_rr_arbiter
module tb_avl_mm_rr_arbiter;

  localparam int N_CH = 2, AW = 32, DW = 32, MAX_PEND = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N_CH*AW-1:0]   in_address;
  logic [N_CH-1:0]      in_read, in_write;
  logic [N_CH*DW-1:0]   in_writedata;
  logic [N_CH*DW/8-1:0] in_byteenable;
  logic [N_CH-1:0]      in_waitrequest, in_readdatavalid;
  logic [DW-1:0]        in_readdata;
  logic [1:0]           in_response;
  logic [AW-1:0]        out_address;
  logic                 out_read, out_write;
  logic [DW-1:0]        out_writedata;
  logic [DW/8-1:0]      out_byteenable;
  logic                 out_waitrequest, out_readdatavalid;
  logic [DW-1:0]        out_readdata;
  logic [1:0]           out_response;
  logic                 err_orphan;

  avl_mm_rr_arbiter #(.N_CH(N_CH), .AW(AW), .DW(DW), .MAX_PEND(MAX_PEND)) dut (
    .clk(clk), .reset(reset),
    .in_address(in_address), .in_read(in_read), .in_write(in_write),
    .in_writedata(in_writedata), .in_byteenable(in_byteenable),
    .in_waitrequest(in_waitrequest), .in_readdata(in_readdata),
    .in_readdatavalid(in_readdatavalid), .in_response(in_response),
    .out_address(out_address), .out_read(out_read), .out_write(out_write),
    .out_writedata(out_writedata), .out_byteenable(out_byteenable),
    .out_waitrequest(out_waitrequest), .out_readdata(out_readdata),
    .out_readdatavalid(out_readdatavalid), .out_response(out_response),
    .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  rd, wr;
    logic [31:0] a0, a1;
    logic        owr, rdv;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        chk;
    logic        e_rd, e_wr;
    logic [31:0] e_addr;
    logic [1:0]  e_wait, e_rdv;
    logic        e_err;
  } vec_t;

  vec_t tv[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic rst, input logic [1:0] rd, input logic [1:0] wr,
                     input logic [31:0] a0, input logic [31:0] a1, input logic owr,
                     input logic rdv, input logic [31:0] rdata, input logic [1:0] resp,
                     input logic chk, input logic e_rd, input logic e_wr, input logic [31:0] e_addr,
                     input logic [1:0] e_wait, input logic [1:0] e_rdv, input logic e_err);
    vec_t v;
    v.rst = rst; v.rd = rd; v.wr = wr; v.a0 = a0; v.a1 = a1; v.owr = owr; v.rdv = rdv;
    v.rdata = rdata; v.resp = resp; v.chk = chk; v.e_rd = e_rd; v.e_wr = e_wr;
    v.e_addr = e_addr; v.e_wait = e_wait; v.e_rdv = e_rdv; v.e_err = e_err;
    tv.push_back(v);
  endtask

  // Random-phase masters and reference model state
  logic          m_act [N_CH];
  logic          m_rd  [N_CH];
  logic          m_wr  [N_CH];
  logic [AW-1:0] m_addr[N_CH];
  logic [DW-1:0] m_wd  [N_CH];
  logic [3:0]    m_be  [N_CH];
  int            pend[$];
  int            mdl_last, mdl_gnt;
  bit            mdl_lock, mdl_err;

  initial begin
    int   sel, r;
    bit   iss, blk;
    logic [1:0] e_wait, e_rdv;

    // rst rd wr a0 a1 owr rdv rdata resp | chk e_rd e_wr e_addr e_wait e_rdv e_err
    add(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,                        0, 0, 0, 0, 2'b11, 2'b00, 0);
    add(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,                        1, 0, 0, 0, 2'b11, 2'b00, 0);
    add(0, 2'b10, 2'b00, 0, 32'h1000, 0, 0, 0, 0,                 1, 1, 0, 32'h1000, 2'b01, 2'b00, 0);
    add(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,                        1, 0, 0, 0, 2'b11, 2'b00, 0);
    add(0, 2'b00, 2'b00, 0, 0, 0, 1, 32'hDEADBEEF, 2'b00,         1, 0, 0, 0, 2'b11, 2'b10, 0);
    add(0, 2'b11, 2'b00, 32'h100, 32'h200, 0, 0, 0, 0,            1, 1, 0, 32'h100, 2'b10, 2'b00, 0);
    add(0, 2'b11, 2'b00, 32'h104, 32'h204, 0, 0, 0, 0,            1, 1, 0, 32'h204, 2'b01, 2'b00, 0);
    add(0, 2'b11, 2'b00, 32'h108, 32'h208, 0, 1, 32'h11111111, 0, 1, 1, 0, 32'h108, 2'b10, 2'b01, 0);
    add(0, 2'b00, 2'b00, 0, 0, 0, 1, 32'h22222222, 2'b00,         1, 0, 0, 0, 2'b11, 2'b10, 0);
    add(0, 2'b00, 2'b00, 0, 0, 0, 1, 32'h33333333, 2'b10,         1, 0, 0, 0, 2'b11, 2'b01, 0);
    add(0, 2'b00, 2'b10, 0, 32'h40, 0, 0, 0, 0,                   1, 0, 1, 32'h40, 2'b01, 2'b00, 0);
    add(0, 2'b10, 2'b01, 32'h20, 32'h300, 1, 0, 0, 0,             1, 0, 1, 32'h20, 2'b11, 2'b00, 0);
    add(0, 2'b10, 2'b01, 32'h20, 32'h300, 1, 0, 0, 0,             1, 0, 1, 32'h20, 2'b11, 2'b00, 0);
    add(0, 2'b10, 2'b01, 32'h20, 32'h300, 1, 0, 0, 0,             1, 0, 1, 32'h20, 2'b11, 2'b00, 0);
    add(0, 2'b10, 2'b01, 32'h20, 32'h300, 0, 0, 0, 0,             1, 0, 1, 32'h20, 2'b10, 2'b00, 0);
    add(0, 2'b10, 2'b00, 0, 32'h300, 0, 0, 0, 0,                  1, 1, 0, 32'h300, 2'b01, 2'b00, 0);
    add(0, 2'b00, 2'b00, 0, 0, 0, 1, 32'h44, 2'b00,               1, 0, 0, 0, 2'b11, 2'b10, 0);
    for (int k = 0; k < 4; k++)
      add(0, 2'b01, 2'b00, 32'h500, 0, 0, 0, 0, 0,                1, 1, 0, 32'h500, 2'b10, 2'b00, 0);
    add(0, 2'b01, 2'b10, 32'h500, 32'h600, 0, 0, 0, 0,            1, 0, 1, 32'h600, 2'b01, 2'b00, 0);
    add(0, 2'b01, 2'b00, 32'h500, 0, 0, 0, 0, 0,                  1, 0, 0, 0, 2'b11, 2'b00, 0);
    add(0, 2'b01, 2'b00, 32'h500, 0, 0, 1, 32'h55, 2'b11,         1, 1, 0, 32'h500, 2'b10, 2'b01, 0);
    add(0, 2'b01, 2'b00, 32'h500, 0, 0, 0, 0, 0,                  1, 0, 0, 0, 2'b11, 2'b00, 0);
    add(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,                        0, 0, 0, 0, 2'b11, 2'b00, 0);
    add(0, 2'b00, 2'b00, 0, 0, 0, 1, 32'h66, 2'b00,               1, 0, 0, 0, 2'b11, 2'b00, 0);
    add(0, 2'b00, 2'b00, 0, 0, 0, 1, 32'h67, 2'b00,               1, 0, 0, 0, 2'b11, 2'b00, 1);
    add(0, 2'b11, 2'b00, 32'h700, 32'h704, 0, 0, 0, 0,            1, 1, 0, 32'h700, 2'b10, 2'b00, 1);
    add(0, 2'b00, 2'b00, 0, 0, 0, 1, 32'h77, 2'b00,               1, 0, 0, 0, 2'b11, 2'b01, 1);
    add(0, 2'b01, 2'b01, 32'h800, 0, 0, 0, 0, 0,                  1, 1, 0, 32'h800, 2'b10, 2'b00, 1);
    add(0, 2'b00, 2'b00, 0, 0, 0, 1, 32'h88, 2'b01,               1, 0, 0, 0, 2'b11, 2'b01, 1);

    reset = 1'b1; in_read = '0; in_write = '0; in_address = '0;
    in_writedata = {32'hAAAA_AAAA, 32'h5555_5555}; in_byteenable = 8'h3C;
    out_waitrequest = 1'b0; out_readdatavalid = 1'b0; out_readdata = '0; out_response = '0;

    foreach (tv[k]) begin
      @(posedge clk); #1;
      reset = tv[k].rst; in_read = tv[k].rd; in_write = tv[k].wr;
      in_address = {tv[k].a1, tv[k].a0};
      out_waitrequest = tv[k].owr; out_readdatavalid = tv[k].rdv;
      out_readdata = tv[k].rdata; out_response = tv[k].resp;
      @(negedge clk);
      if (tv[k].chk) begin
        check($sformatf("v%0d out_read", k), 32'(out_read), 32'(tv[k].e_rd));
        check($sformatf("v%0d out_write", k), 32'(out_write), 32'(tv[k].e_wr));
        check($sformatf("v%0d in_waitrequest", k), 32'(in_waitrequest), 32'(tv[k].e_wait));
        check($sformatf("v%0d in_readdatavalid", k), 32'(in_readdatavalid), 32'(tv[k].e_rdv));
        check($sformatf("v%0d err_orphan", k), 32'(err_orphan), 32'(tv[k].e_err));
        if (tv[k].e_rd || tv[k].e_wr)
          check($sformatf("v%0d out_address", k), out_address, tv[k].e_addr);
        if (tv[k].e_rdv != 2'b00) begin
          check($sformatf("v%0d in_readdata", k), in_readdata, tv[k].rdata);
          check($sformatf("v%0d in_response", k), 32'(in_response), 32'(tv[k].resp));
        end
      end
    end

    // Randomized phase: Avalon-compliant masters hold each command until accepted.
    @(posedge clk); #1;
    reset = 1'b1; in_read = '0; in_write = '0; out_readdatavalid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    pend.delete(); mdl_last = N_CH - 1; mdl_gnt = 0; mdl_lock = 0; mdl_err = 0;
    for (int i = 0; i < N_CH; i++) m_act[i] = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N_CH; i++) begin
        if (!m_act[i] && $urandom_range(0, 1) == 1) begin
          r = $urandom_range(0, 9);
          m_act[i] = 1'b1;
          m_rd[i] = (r < 5) || (r == 9);
          m_wr[i] = (r >= 5);
          m_addr[i] = $urandom; m_wd[i] = $urandom; m_be[i] = 4'($urandom);
        end
        in_read[i]  = m_act[i] & m_rd[i];
        in_write[i] = m_act[i] & m_wr[i];
        in_address[i*AW +: AW]   = m_addr[i];
        in_writedata[i*DW +: DW] = m_wd[i];
        in_byteenable[i*4 +: 4]  = m_be[i];
      end
      out_waitrequest = ($urandom_range(0, 2) == 0);
      out_readdatavalid = (pend.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 60) == 0);
      out_readdata = $urandom; out_response = 2'($urandom);

      @(negedge clk);
      blk = (pend.size() == MAX_PEND) && !out_readdatavalid;
      iss = 0; sel = 0;
      if (mdl_lock) begin
        sel = mdl_gnt;
        iss = (in_read[sel] | in_write[sel]) && !(in_read[sel] && blk);
      end else begin
        for (int k = 1; k <= N_CH; k++) begin
          int j;
          j = (mdl_last + k) % N_CH;
          if (!iss && (in_read[j] | in_write[j]) && !(in_read[j] && blk)) begin
            iss = 1; sel = j;
          end
        end
      end
      e_wait = '1;
      if (iss && !out_waitrequest) e_wait[sel] = 1'b0;
      e_rdv = '0;
      if (out_readdatavalid && pend.size() > 0) e_rdv[pend[0]] = 1'b1;

      check("rnd out_read", 32'(out_read), 32'(iss && in_read[sel]));
      check("rnd out_write", 32'(out_write), 32'(iss && !in_read[sel]));
      check("rnd in_waitrequest", 32'(in_waitrequest), 32'(e_wait));
      check("rnd in_readdatavalid", 32'(in_readdatavalid), 32'(e_rdv));
      check("rnd err_orphan", 32'(err_orphan), 32'(mdl_err));
      if (iss) begin
        check("rnd out_address", out_address, m_addr[sel]);
        check("rnd out_byteenable", 32'(out_byteenable), 32'(m_be[sel]));
        if (!in_read[sel]) check("rnd out_writedata", out_writedata, m_wd[sel]);
      end
      if (e_rdv != 2'b00) check("rnd in_readdata", in_readdata, out_readdata);

      if (out_readdatavalid) begin
        if (pend.size() > 0) void'(pend.pop_front());
        else mdl_err = 1;
      end
      if (iss && !out_waitrequest) begin
        if (in_read[sel]) pend.push_back(sel);
        mdl_last = sel;
      end
      mdl_lock = iss && out_waitrequest;
      if (iss) mdl_gnt = sel;
      for (int i = 0; i < N_CH; i++)
        if (e_wait[i] == 1'b0) m_act[i] = 1'b0;

      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
